// File: rtl/param_reg_bank.sv
// param_reg_bank: host-writable control registers with system-owned status reg0, dirty flags and registered read port
module param_reg_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {32'h0, 32'h0000000A, 32'h55555556, 32'h0}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W/8-1:0]          wr_be,
  output logic                         done,
  output logic                         err,
  input  logic                         sys_we,
  input  logic [DATA_W-1:0]            sys_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   rd_regs,
  output logic [NUM_REGS-1:0]          dirty,
  input  logic [NUM_REGS-1:0]          dirty_clr
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic done_q, err_q, err_d, accept, legal;
  assign accept = state_q == IDLE && wr_en;
  assign legal = wr_addr != '0 && int'(wr_addr) < NUM_REGS;
  assign state_d = wr_en ? ACK : IDLE;
  // err stays attached to the ack for as long as done is held
  assign err_d = accept ? !legal : wr_en && err_q;
  assign rd_data_d = int'(rd_addr) < NUM_REGS ? regs_q[rd_addr] : '0;
  always_comb begin
    regs_d = regs_q;
    dirty_d = dirty_q & ~dirty_clr;
    if (sys_we) regs_d[0] = sys_data;
    if (accept && legal) begin
      for (int k = 0; k < DATA_W/8; k++)
        if (wr_be[k]) regs_d[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
      dirty_d[wr_addr] = 1'b1;
    end
    dirty_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      err_q <= 1'b0;
      dirty_q <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
    end else begin
      state_q <= state_d;
      done_q <= wr_en;
      err_q <= err_d;
      dirty_q <= dirty_d;
      rd_data_q <= rd_data_d;
      regs_q <= regs_d;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign rd_regs[i*DATA_W +: DATA_W] = regs_q[i];
  end
  assign done = done_q;
  assign err = err_q;
  assign dirty = dirty_q;
  assign rd_data = rd_data_q;
endmodule
